// File: rtl/udp_sample_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : udp_sample_packer                                          |
// | Description : Buffers 16-bit samples in a circular word FIFO and, once a |
// |               full packet is buffered, asks the UDP core for a packet    |
// |               and streams each word as two bytes, MSB first.             |
// | Ports       : clk, rst          - clock / synchronous active-high reset  |
// |               sample_valid/data - sample input                           |
// |               sample_ready      - buffer not full                        |
// |               level             - words currently buffered               |
// |               tx_start_en       - one-cycle packet request pulse         |
// |               tx_byte_num       - payload length in bytes                |
// |               tx_req / tx_data  - byte request / byte (1-cycle latency)  |
// |               tx_done           - packet finished strobe from UDP core   |
// |               busy              - FSM not idle                           |
// |               overflow, pkt_err - sticky error flags                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module udp_sample_packer #(
    parameter int DEPTH_WIDTH = 10,
    parameter int PKT_WORDS   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [15:0]            sample_data,
    output logic                   sample_ready,
    output logic [DEPTH_WIDTH:0]   level,
    output logic                   tx_start_en,
    output logic [15:0]            tx_byte_num,
    input  logic                   tx_req,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   overflow,
    output logic                   pkt_err
);

    localparam int                   c_DEPTH     = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] c_FULL      = (DEPTH_WIDTH+1)'(c_DEPTH);
    localparam logic [DEPTH_WIDTH:0] c_PKT_WORDS = (DEPTH_WIDTH+1)'(PKT_WORDS);
    localparam logic [15:0]          c_PKT_BYTES = 16'(2 * PKT_WORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [15:0] mem [c_DEPTH];

    state_t                 state_q,       state_d;
    logic [DEPTH_WIDTH-1:0] wr_ptr_q,      wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q,      rd_ptr_d;
    logic [DEPTH_WIDTH:0]   level_q,       level_d;
    logic [15:0]            byte_cnt_q,    byte_cnt_d;
    logic                   phase_lo_q,    phase_lo_d;
    logic [7:0]             tx_data_q,     tx_data_d;
    logic                   tx_start_en_q, tx_start_en_d;
    logic [15:0]            tx_byte_num_q, tx_byte_num_d;
    logic                   overflow_q,    overflow_d;
    logic                   pkt_err_q,     pkt_err_d;

    logic        w_push;
    logic        w_pop;
    logic [15:0] w_head;

    assign sample_ready = (level_q != c_FULL);
    assign w_push       = sample_valid && sample_ready;
    assign w_head       = mem[rd_ptr_q];

    assign level        = level_q;
    assign tx_start_en  = tx_start_en_q;
    assign tx_byte_num  = tx_byte_num_q;
    assign tx_data      = tx_data_q;
    assign busy         = (state_q != IDLE);
    assign overflow     = overflow_q;
    assign pkt_err      = pkt_err_q;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        phase_lo_d    = phase_lo_q;
        tx_data_d     = tx_data_q;
        tx_start_en_d = 1'b0;
        tx_byte_num_d = tx_byte_num_q;
        overflow_d    = overflow_q;
        pkt_err_d     = pkt_err_q;
        w_pop         = 1'b0;

        if (sample_valid && !sample_ready) begin
            overflow_d = 1'b1;
        end

        // Byte requests are only legal while a packet is being sent.
        if (tx_req && (state_q != SEND)) begin
            tx_data_d = 8'h00;
            pkt_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Starts are gated purely on buffered words, so SEND can
                // never pop from an empty buffer.
                if (level_q >= c_PKT_WORDS) begin
                    state_d       = START;
                    tx_byte_num_d = c_PKT_BYTES;
                    tx_start_en_d = 1'b1;
                end
            end
            START: begin
                state_d    = SEND;
                byte_cnt_d = 16'd0;
                phase_lo_d = 1'b0;
            end
            SEND: begin
                if (tx_done) begin
                    // Early finish: a half-sent word stays at the head and is
                    // resent from its high byte in the next packet.
                    state_d   = IDLE;
                    pkt_err_d = 1'b1;
                end else if (tx_req) begin
                    tx_data_d  = phase_lo_q ? w_head[7:0] : w_head[15:8];
                    phase_lo_d = ~phase_lo_q;
                    w_pop      = phase_lo_q;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if ((byte_cnt_q + 16'd1) == c_PKT_BYTES) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = w_push ? (wr_ptr_q + DEPTH_WIDTH'(1)) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + DEPTH_WIDTH'(1)) : rd_ptr_q;

        case ({w_push, w_pop})
            2'b10:   level_d = level_q + (DEPTH_WIDTH+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_WIDTH+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Sample storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[wr_ptr_q] <= sample_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            byte_cnt_q    <= 16'd0;
            phase_lo_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_start_en_q <= 1'b0;
            tx_byte_num_q <= 16'd0;
            overflow_q    <= 1'b0;
            pkt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            byte_cnt_q    <= byte_cnt_d;
            phase_lo_q    <= phase_lo_d;
            tx_data_q     <= tx_data_d;
            tx_start_en_q <= tx_start_en_d;
            tx_byte_num_q <= tx_byte_num_d;
            overflow_q    <= overflow_d;
            pkt_err_q     <= pkt_err_d;
        end
    end

endmodule
`default_nettype wire
